// File: rtl/hd_frame_collector_if.sv
// ---------------------------------------------------------------------------
// hd_frame_collector_if
//
// Groups the hard-decision stream and the host frame-read port of
// hd_frame_collector. Clock and reset are not part of the bundle.
//
//   datavalid    stream word qualifier
//   HD_in        stream word
//   host_addr    word index within the bank currently presented to the host
//   host_rd_en   read strobe; host_dout updates one cycle later
//   host_release one-cycle pulse that frees the presented bank
//   frame_ready  presented bank holds a complete frame
//   rd_bank      index of the presented bank
//   host_dout    registered read data
//   overflow     sticky: a frame was dropped with both banks full
//   trunc_err    sticky: datavalid fell in the middle of a frame
//   frame_count  frames completed into a bank, wrapping
//
// master: the stream source / host side.  slave: the collector.
// ---------------------------------------------------------------------------
interface hd_frame_collector_if #(
    parameter int HDDW            = 32,
    parameter int CYCLECOUNTWIDTH = 8,
    parameter int FCW             = 16
);
    logic                       datavalid;
    logic [HDDW-1:0]            HD_in;
    logic [CYCLECOUNTWIDTH-1:0] host_addr;
    logic                       host_rd_en;
    logic                       host_release;
    logic                       frame_ready;
    logic                       rd_bank;
    logic [HDDW-1:0]            host_dout;
    logic                       overflow;
    logic                       trunc_err;
    logic [FCW-1:0]             frame_count;

    modport master (
        output datavalid,
        output HD_in,
        output host_addr,
        output host_rd_en,
        output host_release,
        input  frame_ready,
        input  rd_bank,
        input  host_dout,
        input  overflow,
        input  trunc_err,
        input  frame_count
    );

    modport slave (
        input  datavalid,
        input  HD_in,
        input  host_addr,
        input  host_rd_en,
        input  host_release,
        output frame_ready,
        output rd_bank,
        output host_dout,
        output overflow,
        output trunc_err,
        output frame_count
    );
endinterface

// File: rtl/hd_frame_collector.sv
// ---------------------------------------------------------------------------
// hd_frame_collector
//
// Reassembles the decoder's 32-bit hard-decision stream into MAXOUTCYCLES-word
// frames held in two ping-pong banks, and presents completed frames to a host
// through a registered random-access read port with a release handshake.
// Frames arriving while both banks are full are dropped (overflow); frames
// whose datavalid falls early are discarded (trunc_err).
//
// Ports:
//   rdclk  clock, rising edge
//   rst    synchronous, active-low reset
//   bus    hd_frame_collector_if.slave: stream in, host read/release port,
//          status outputs (see the interface file for the signal list)
// ---------------------------------------------------------------------------
module hd_frame_collector #(
    parameter int HDDW            = 32,
    parameter int MAXOUTCYCLES    = 223,
    parameter int CYCLECOUNTWIDTH = 8,
    parameter int FCW             = 16
) (
    input  logic                 rdclk,
    input  logic                 rst,
    hd_frame_collector_if.slave  bus
);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    localparam logic [CYCLECOUNTWIDTH-1:0] LAST_IDX = CYCLECOUNTWIDTH'(MAXOUTCYCLES - 1);
    localparam logic [CYCLECOUNTWIDTH-1:0] CNT_ONE  = CYCLECOUNTWIDTH'(1);

    logic [1:0]                 state;
    logic [CYCLECOUNTWIDTH-1:0] wcnt;
    logic [1:0]                 full;
    logic [1:0]                 full_next;
    logic                       wr_bank;
    logic                       rd_bank_r;
    logic                       overflow_r;
    logic                       trunc_err_r;
    logic [FCW-1:0]             frame_count_r;
    logic [HDDW-1:0]            dout_p1;

    logic [HDDW-1:0]            bank_mem [2][MAXOUTCYCLES];

    logic                       wr_en;
    logic [CYCLECOUNTWIDTH-1:0] wr_addr;
    logic                       frame_done;
    logic                       release_ok;

    // Write-side decode. IDLE writes word 0 directly so back-to-back frames
    // need no gap; all other words land at the running count.
    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = wcnt;
        frame_done = 1'b0;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (bus.datavalid && !full[wr_bank]) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                    end
                end
                ST_COLLECT: begin
                    if (bus.datavalid) begin
                        wr_en      = 1'b1;
                        frame_done = (wcnt == LAST_IDX);
                    end
                end
                default: ;
            endcase
        end
    end

    // A release only counts when the presented bank is actually full.
    assign release_ok = bus.host_release & full[rd_bank_r];

    // Completion and release never hit the same bank: the bank being filled
    // is either not rd_bank, or rd_bank while it is empty (so no release).
    always_comb begin
        full_next = full;
        if (frame_done) begin
            full_next[wr_bank] = 1'b1;
        end
        if (release_ok) begin
            full_next[rd_bank_r] = 1'b0;
        end
    end

    // Control: frame FSM, bank status, pointers, sticky flags, frame counter.
    // IDLE tests the registered full[] so a release on the same edge does not
    // rescue an incoming frame; that frame is dropped.
    always_ff @(posedge rdclk) begin
        if (!rst) begin
            state         <= ST_SYNC;
            wcnt          <= '0;
            full          <= 2'b00;
            wr_bank       <= 1'b0;
            rd_bank_r     <= 1'b0;
            overflow_r    <= 1'b0;
            trunc_err_r   <= 1'b0;
            frame_count_r <= '0;
        end else begin
            full <= full_next;
            if (release_ok) begin
                rd_bank_r <= ~rd_bank_r;
            end

            case (state)
                // Reset may land mid-stream; wait for a gap to realign.
                ST_SYNC: begin
                    if (!bus.datavalid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.datavalid) begin
                        wcnt <= CNT_ONE;
                        if (full[wr_bank]) begin
                            overflow_r <= 1'b1;
                            state      <= ST_DROP;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (bus.datavalid) begin
                        if (wcnt == LAST_IDX) begin
                            wcnt          <= '0;
                            wr_bank       <= ~wr_bank;
                            frame_count_r <= frame_count_r + FCW'(1);
                            state         <= ST_IDLE;
                        end else begin
                            wcnt <= wcnt + CNT_ONE;
                        end
                    end else begin
                        // Bank stays unmarked; its partial contents are
                        // overwritten by the next frame.
                        trunc_err_r <= 1'b1;
                        wcnt        <= '0;
                        state       <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (bus.datavalid) begin
                        if (wcnt == LAST_IDX) begin
                            wcnt  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            wcnt <= wcnt + CNT_ONE;
                        end
                    end else begin
                        trunc_err_r <= 1'b1;
                        wcnt        <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

    // Stream write port: bank storage carries no reset.
    always_ff @(posedge rdclk) begin
        if (wr_en) begin
            bank_mem[wr_bank][wr_addr] <= bus.HD_in;
        end
    end

    // Host read port, one-cycle latency; holds when not strobed.
    // Addresses past the frame length return unspecified data.
    always_ff @(posedge rdclk) begin
        if (!rst) begin
            dout_p1 <= '0;
        end else if (bus.host_rd_en) begin
            dout_p1 <= bank_mem[rd_bank_r][bus.host_addr];
        end
    end

    assign bus.frame_ready = full[rd_bank_r];
    assign bus.rd_bank     = rd_bank_r;
    assign bus.host_dout   = dout_p1;
    assign bus.overflow    = overflow_r;
    assign bus.trunc_err   = trunc_err_r;
    assign bus.frame_count = frame_count_r;

endmodule

// File: tb/tb_hd_frame_collector.sv
// ---------------------------------------------------------------------------
// tb_hd_frame_collector
//
// Directed bench for hd_frame_collector. Inputs change on the falling edge,
// outputs are sampled on the falling edge, midway between rising edges.
// ---------------------------------------------------------------------------
module tb_hd_frame_collector;

    logic rdclk = 1'b0;
    logic rst   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    hd_frame_collector_if #(.HDDW(32), .CYCLECOUNTWIDTH(8), .FCW(16)) bus ();

    hd_frame_collector #(
        .HDDW(32), .MAXOUTCYCLES(223), .CYCLECOUNTWIDTH(8), .FCW(16)
    ) dut (
        .rdclk (rdclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 rdclk = ~rdclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge rdclk);
    endtask

    // Drives n consecutive valid words base+0..base+n-1; datavalid stays high.
    task automatic send_words(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            bus.datavalid = 1'b1;
            bus.HD_in     = base + 32'(k);
            @(negedge rdclk);
        end
    endtask

    task automatic gap(input int n);
        bus.datavalid = 1'b0;
        tick(n);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.host_addr  = a;
        bus.host_rd_en = 1'b1;
        @(negedge rdclk);
        bus.host_rd_en = 1'b0;
        d = bus.host_dout;
    endtask

    task automatic release_bank;
        bus.host_release = 1'b1;
        @(negedge rdclk);
        bus.host_release = 1'b0;
    endtask

    // Reset with the stream idle, then leave a gap so SYNC exits.
    task automatic do_reset;
        rst              = 1'b0;
        bus.datavalid    = 1'b0;
        bus.HD_in        = '0;
        bus.host_addr    = '0;
        bus.host_rd_en   = 1'b0;
        bus.host_release = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;

        // Reset state
        rst              = 1'b0;
        bus.datavalid    = 1'b0;
        bus.HD_in        = '0;
        bus.host_addr    = '0;
        bus.host_rd_en   = 1'b0;
        bus.host_release = 1'b0;
        tick(3);
        chk("rst_frame_ready", 32'(bus.frame_ready), 0);
        chk("rst_rd_bank",     32'(bus.rd_bank), 0);
        chk("rst_host_dout",   bus.host_dout, 0);
        chk("rst_overflow",    32'(bus.overflow), 0);
        chk("rst_trunc_err",   32'(bus.trunc_err), 0);
        chk("rst_frame_count", 32'(bus.frame_count), 0);

        // Single frame
        rst = 1'b1;
        gap(2);
        send_words(32'hA500_0000, 223);
        bus.datavalid = 1'b0;
        chk("single_ready", 32'(bus.frame_ready), 1);
        chk("single_rd_bank", 32'(bus.rd_bank), 0);
        chk("single_count", 32'(bus.frame_count), 1);
        rd(8'd0, d);   chk("single_addr0", d, 32'hA500_0000);
        rd(8'd100, d); chk("single_addr100", d, 32'hA500_0064);
        rd(8'd222, d); chk("single_addr222", d, 32'hA500_00DE);
        bus.host_addr = 8'd5;
        tick(2);
        chk("dout_hold", bus.host_dout, 32'hA500_00DE);

        // Back-to-back, then a third contiguous frame that must be dropped
        do_reset();
        send_words(32'hB000_0000, 446);
        chk("b2b_ready", 32'(bus.frame_ready), 1);
        chk("b2b_count", 32'(bus.frame_count), 2);
        chk("b2b_overflow", 32'(bus.overflow), 0);
        send_words(32'hB000_0000 + 32'd446, 223);
        bus.datavalid = 1'b0;
        tick(1);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.frame_count), 2);
        chk("ovf_trunc", 32'(bus.trunc_err), 0);
        rd(8'd0, d);   chk("ovf_bank0_addr0", d, 32'hB000_0000);
        rd(8'd222, d); chk("ovf_bank0_addr222", d, 32'hB000_00DE);
        release_bank();
        chk("rel1_rd_bank", 32'(bus.rd_bank), 1);
        chk("rel1_ready", 32'(bus.frame_ready), 1);
        rd(8'd0, d);   chk("rel1_addr0", d, 32'hB000_00DF);
        rd(8'd222, d); chk("rel1_addr222", d, 32'hB000_01BD);
        release_bank();
        chk("rel2_rd_bank", 32'(bus.rd_bank), 0);
        chk("rel2_ready", 32'(bus.frame_ready), 0);
        send_words(32'hC000_0000, 223);
        bus.datavalid = 1'b0;
        chk("f4_count", 32'(bus.frame_count), 3);
        chk("f4_ready", 32'(bus.frame_ready), 1);
        rd(8'd5, d);   chk("f4_addr5", d, 32'hC000_0005);

        // Truncation after word 100
        do_reset();
        send_words(32'h7700_0000, 101);
        gap(1);
        chk("trunc_flag", 32'(bus.trunc_err), 1);
        chk("trunc_ready", 32'(bus.frame_ready), 0);
        chk("trunc_count", 32'(bus.frame_count), 0);
        send_words(32'hD000_0000, 223);
        bus.datavalid = 1'b0;
        chk("trunc_next_ready", 32'(bus.frame_ready), 1);
        chk("trunc_next_count", 32'(bus.frame_count), 1);
        rd(8'd0, d);   chk("trunc_next_addr0", d, 32'hD000_0000);
        rd(8'd150, d); chk("trunc_next_addr150", d, 32'hD000_0096);

        // Reset mid-frame with datavalid held high
        do_reset();
        send_words(32'h1100_0000, 50);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        send_words(32'hE000_0000, 30);
        chk("midrst_count_pre", 32'(bus.frame_count), 0);
        chk("midrst_ready_pre", 32'(bus.frame_ready), 0);
        gap(1);
        chk("midrst_trunc", 32'(bus.trunc_err), 0);
        send_words(32'hF000_0000, 223);
        bus.datavalid = 1'b0;
        chk("midrst_count", 32'(bus.frame_count), 1);
        chk("midrst_ready", 32'(bus.frame_ready), 1);
        rd(8'd0, d);   chk("midrst_addr0", d, 32'hF000_0000);
        rd(8'd222, d); chk("midrst_addr222", d, 32'hF000_00DE);

        // Release of bank 0 on the edge bank 1 completes
        do_reset();
        send_words(32'h3000_0000, 223);
        send_words(32'h4000_0000, 222);
        bus.HD_in        = 32'h4000_00DE;
        bus.host_release = 1'b1;
        @(negedge rdclk);
        bus.host_release = 1'b0;
        bus.datavalid    = 1'b0;
        chk("sim_rd_bank", 32'(bus.rd_bank), 1);
        chk("sim_ready", 32'(bus.frame_ready), 1);
        chk("sim_count", 32'(bus.frame_count), 2);
        rd(8'd222, d); chk("sim_addr222", d, 32'h4000_00DE);
        release_bank();
        chk("sim_rel_rd_bank", 32'(bus.rd_bank), 0);
        chk("sim_rel_ready", 32'(bus.frame_ready), 0);
        release_bank();
        chk("ignored_release", 32'(bus.rd_bank), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hd_frame_collector.md
# hd_frame_collector

Receive-side companion to the decoder output FIFO. It sits on the `rdclk` domain and consumes the 32-bit hard-decision stream (`datavalid` + `HD_out`). It reassembles each 223-word (7136-bit) decoded frame into one of two ping-pong frame banks and hands completed frames to the host through a random-access read port with a release handshake. It also flags dropped frames (overflow) and truncated frames.

## Interface
Parameters:
- HDDW, 32, word width of the incoming stream and host read data
- MAXOUTCYCLES, 223, words per frame
- CYCLECOUNTWIDTH, 8, width of the word counter and host address
- FCW, 16, width of the completed-frame counter

Ports:
- rdclk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low
- datavalid  in  1  stream word qualifier; high for MAXOUTCYCLES consecutive cycles per frame, may stay high across back-to-back frames
- HD_in  in  HDDW  stream word
- host_addr  in  CYCLECOUNTWIDTH  word index (0..222) within the current read bank
- host_rd_en  in  1  read strobe
- host_release  in  1  one-cycle pulse; frees the current read bank
- frame_ready  out  1  current read bank holds a complete frame
- rd_bank  out  1  index of the bank the host is reading
- host_dout  out  HDDW  registered read data
- overflow  out  1  sticky; a frame was dropped because both banks were full
- trunc_err  out  1  sticky; datavalid fell mid-frame
- frame_count  out  FCW  number of frames completed into a bank, wraps modulo 2^FCW

## Operation
- Storage: two banks, each MAXOUTCYCLES×HDDW. Bank status `full[1:0]`. Write bank pointer `wr_bank`, read pointer `rd_bank`.
- States:
  - SYNC (entered on reset): ignore input until `datavalid`=0 is sampled, then go to IDLE. This prevents misalignment after reset mid-stream.
  - IDLE, when `datavalid`=1:
    - If `full[wr_bank]`=0: write HD_in to addr 0, set wcnt=1, go to COLLECT.
    - Otherwise: set `overflow`, set wcnt=1, go to DROP.
  - COLLECT, when `datavalid`=1: write to addr wcnt.
    - If wcnt=MAXOUTCYCLES-1: set `full[wr_bank]`, toggle `wr_bank`, increment `frame_count`, set wcnt=0, go to IDLE.
    - Otherwise: wcnt+1.
  - COLLECT, when `datavalid`=0: set `trunc_err`, leave the bank unmarked (contents discarded), set wcnt=0, go to IDLE.
  - DROP: count words without writing.
    - When wcnt reaches MAXOUTCYCLES-1: go to IDLE.
    - If `datavalid`=0 early: set `trunc_err`, go to IDLE.
- Back-to-back frames: IDLE accepts word 0 on the cycle immediately after the last word of the previous frame, so no gap is required.
- Host side:
  - `frame_ready` = `full[rd_bank]`.
  - `host_release` while `frame_ready`=1 clears `full[rd_bank]` and toggles `rd_bank`.
  - `host_release` while `frame_ready`=0 is ignored.
- Simultaneous completion and release: both take effect in the same cycle. They always target different banks, except when both banks are empty-then-filling, where completion targets `wr_bank`≠`rd_bank` or the same bank, which is free.
- A release that frees `wr_bank` in the same cycle that IDLE checks `full[wr_bank]` uses the pre-release value, so that frame is dropped (overflow).
- `host_addr` ≥ MAXOUTCYCLES: `host_dout` is undefined, with no side effects.
- The host may read with `frame_ready`=0; data is stale but there is no hazard. The write bank is never `rd_bank` while `rd_bank` is full.

## Timing
- Reset values:
  - state SYNC, wcnt 0, `full` 00, `wr_bank` 0, `rd_bank` 0
  - `frame_ready` 0, `host_dout` 0, `overflow` 0, `trunc_err` 0, `frame_count` 0
- Stream inputs are sampled at rising edge T; the word is written at edge T.
- When the last word is sampled at edge T: `frame_ready` (if `rd_bank`=that bank) and `frame_count` update at T, visible after T.
- Read latency 1: `host_addr`/`host_rd_en` sampled at edge T, `host_dout` valid after T. `host_dout` holds when `host_rd_en`=0.
- Release: `host_release` sampled at T; `frame_ready`/`rd_bank` change after T.
- Sticky flags are cleared only by reset.

## Test plan
- Single frame: after reset, hold `datavalid`=0 for 2 cycles, then send 223 words with HD_in=0xA5000000+k → `frame_ready`=1 with `rd_bank`=0; reading addr 0/100/222 returns 0xA5000000/0xA5000064/0xA50000DE; `frame_count`=1.
- Back-to-back: 446 continuous valid words, no release → both banks full, `frame_count`=2, `overflow`=0; release → `rd_bank`=1, `frame_ready`=1, addr 0 returns word 223.
- Overflow: third contiguous frame with both banks full → `overflow`=1, `frame_count` stays 2, bank contents unchanged. Release twice, then a fourth frame is accepted into bank 0 and `frame_count`=3.
- Truncation: `datavalid` drops after word 100 → `trunc_err`=1, `frame_ready`=0, `frame_count`=0; a following full frame lands in bank 0 correctly.
- Reset mid-frame with `datavalid` held high → no writes until `datavalid` goes low once; the next full frame completes normally.
- Release of `rd_bank` 0 on the same edge that bank 1 completes → after the edge `rd_bank`=1, `frame_ready`=1, `full`=10.
